// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store access unit: FSM states,
// access-mode codes, byte-enable patterns and size/alignment helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    localparam logic [2:0] MODE_W  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_B  = 3'b010;
    localparam logic [2:0] MODE_HS = 3'b101;
    localparam logic [2:0] MODE_BS = 3'b110;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // The reserved size code 11 falls through to word.
    function automatic logic size_is_byte(input logic [1:0] size);
        return size == 2'b10;
    endfunction

    function automatic logic size_is_half(input logic [1:0] size);
        return size == 2'b01;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size_is_byte(size)) return 1'b0;
        if (size_is_half(size)) return addr_lo[0];
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Combinational lane formatting: store byte enables/replication and
// load lane extraction with sign or zero extension.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_fmt = rdata_in;

        case (addr_lo)
            2'd0:    byte_lane = rdata_in[7:0];
            2'd1:    byte_lane = rdata_in[15:8];
            2'd2:    byte_lane = rdata_in[23:16];
            default: byte_lane = rdata_in[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];

        if (size_is_byte(mode[1:0])) begin
            be        = BE_BYTE << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_fmt = mode[2] ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
        end else if (size_is_half(mode[1:0])) begin
            be        = BE_HALF << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            rdata_fmt = mode[2] ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one access at a time, runs it on the
// memory bus with a timeout, and reports completion with error flags.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_valid,
    input  logic               acc_we,
    input  logic [2:0]         acc_mode,
    input  logic [31:0]        acc_addr,
    input  logic [31:0]        acc_wdata,
    output logic               acc_ready,
    output logic               done,
    output logic               err_misalign,
    output logic               err_timeout,
    output logic [31:0]        rdata,
    mem_access_unit_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state;
    logic [2:0]    lat_mode;
    logic [1:0]    lat_addr_lo;
    logic [CW-1:0] cnt;
    logic          pend_misalign;
    logic          pend_timeout;

    logic [2:0]    fmt_mode;
    logic [1:0]    fmt_addr_lo;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic [31:0]   fmt_rdata;

    // Store formatting comes from the live request at accept; load
    // extraction uses the latched request while the bus is busy.
    assign fmt_mode    = (state == S_IDLE) ? acc_mode : lat_mode;
    assign fmt_addr_lo = (state == S_IDLE) ? acc_addr[1:0] : lat_addr_lo;

    mem_lane_fmt u_lane_fmt (
        .mode      (fmt_mode),
        .addr_lo   (fmt_addr_lo),
        .wdata     (acc_wdata),
        .rdata_in  (bus.bus_rdata),
        .be        (fmt_be),
        .wdata_rep (fmt_wdata),
        .rdata_fmt (fmt_rdata)
    );

    // NOTE: all state uses non-blocking assignments under one async reset so every register updates together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            acc_ready     <= 1'b1;
            done          <= 1'b0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
            rdata         <= '0;
            lat_mode      <= '0;
            lat_addr_lo   <= '0;
            cnt           <= '0;
            pend_misalign <= 1'b0;
            pend_timeout  <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            done         <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc_valid) begin
                        lat_mode      <= acc_mode;
                        lat_addr_lo   <= acc_addr[1:0];
                        bus.bus_we    <= acc_we;
                        pend_timeout  <= 1'b0;
                        acc_ready     <= 1'b0;
                        if (is_misaligned(acc_mode[1:0], acc_addr[1:0])) begin
                            pend_misalign <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            pend_misalign <= 1'b0;
                            bus.bus_req   <= 1'b1;
                            bus.bus_addr  <= {acc_addr[31:2], 2'b00};
                            bus.bus_be    <= fmt_be;
                            bus.bus_wdata <= fmt_wdata;
                            cnt           <= '0;
                            state         <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (bus.bus_ack) begin
                        if (!bus.bus_we) rdata <= fmt_rdata;
                        bus.bus_req <= 1'b0;
                        state       <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        pend_timeout <= 1'b1;
                        bus.bus_req  <= 1'b0;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    done         <= 1'b1;
                    err_misalign <= pend_misalign;
                    err_timeout  <= pend_timeout;
                    acc_ready    <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
